// File: rtl/pdp8_panel_pkg.sv
// pdp8_panel_pkg: shared FSM/pulse-kind encodings, default parameters and a width helper.
// Build option: PANEL_AUTORUN_EN (see pdp8_panel_ctrl).
package pdp8_panel_pkg;

  typedef enum logic [1:0] {
    S_POR,
    S_IDLE,
    S_PULSE,
    S_WAITREL
  } state_t;

  typedef enum logic [1:0] {
    KIND_RUN,
    KIND_HALT,
    KIND_RSTCLR
  } kind_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_PULSE_CYCLES    = 4;
  localparam int DEF_POR_CYCLES      = 16;

  // Counter width for a 0..n-1 count, never less than one bit.
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pdp8_panel_if.sv
// pdp8_panel_if: panel <-> CPU control bundle (running status in, sw_* pulses and busy out).
// master = panel controller, slave = CPU side.
interface pdp8_panel_if;
  logic running;
  logic sw_RUN;
  logic sw_HALT;
  logic sw_RESET;
  logic sw_CLEAR;
  logic busy;

  modport master (
    input  running,
    output sw_RUN, sw_HALT, sw_RESET, sw_CLEAR, busy
  );

  modport slave (
    output running,
    input  sw_RUN, sw_HALT, sw_RESET, sw_CLEAR, busy
  );
endinterface

// File: rtl/pdp8_debounce.sv
// pdp8_debounce: 2-FF synchroniser, stability counter and press strobe for one active-low button.
// Ports: CLK, RESET (async high), nIN raw button, level debounced pressed, press 1-cycle strobe.
module pdp8_debounce
  import pdp8_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic RESET,
  input  logic nIN,
  output logic level,
  output logic press
);

  localparam int CW = cw(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Synchroniser holds the raw active-low value, so reset 1 = released.
  logic s1_q, s2_q;
  logic lvl_q, lvl_d;
  logic prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic synced;

  assign synced = ~s2_q;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (synced != lvl_q) begin
      if (cnt_q == LAST) lvl_d = synced;
      else cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= nIN;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      prev_q <= lvl_q;
      cnt_q  <= cnt_d;
    end
  end

  assign level = lvl_q;
  assign press = lvl_q & ~prev_q;

endmodule

// File: rtl/pdp8_panel_ctrl.sv
// pdp8_panel_ctrl: front-panel run controller; debounces nBUT1/nBUT2, runs POR, emits sw_* pulses.
// Ports: CLK, RESET (async high), nBUT1, nBUT2, cpu (pdp8_panel_if.master). Option: PANEL_AUTORUN_EN.
module pdp8_panel_ctrl
  import pdp8_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int POR_CYCLES      = DEF_POR_CYCLES
) (
  input  logic CLK,
  input  logic RESET,
  input  logic nBUT1,
  input  logic nBUT2,
  pdp8_panel_if.master cpu
);

  localparam int CWP = cw(POR_CYCLES);
  localparam int CWU = cw(PULSE_CYCLES);
  localparam int CW  = (CWP > CWU) ? CWP : CWU;
  localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] PUL_LAST = CW'(PULSE_CYCLES - 1);

  logic lvl1, lvl2, press1, press2;

  pdp8_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .CLK   (CLK),
    .RESET (RESET),
    .nIN   (nBUT1),
    .level (lvl1),
    .press (press1)
  );

  pdp8_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
    .CLK   (CLK),
    .RESET (RESET),
    .nIN   (nBUT2),
    .level (lvl2),
    .press (press2)
  );

  state_t state_q, state_d;
  kind_t  kind_q, kind_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d;
  logic halt_q, halt_d;
  logic rst_q, rst_d;
  logic clr_q, clr_d;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_POR: begin
        if (cnt_q == POR_LAST) begin
          cnt_d = '0;
`ifdef PANEL_AUTORUN_EN
          state_d = S_PULSE;
          kind_d  = KIND_RUN;
`else
          state_d = S_WAITREL;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        // RESET/CLEAR button has priority over RUN/HALT.
        if (press2) begin
          state_d = S_PULSE;
          kind_d  = KIND_RSTCLR;
        end else if (press1) begin
          state_d = S_PULSE;
          kind_d  = cpu.running ? KIND_HALT : KIND_RUN;
        end
      end
      S_PULSE: begin
        if (cnt_q == PUL_LAST) begin
          cnt_d   = '0;
          state_d = S_WAITREL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAITREL: begin
        cnt_d = '0;
        if (!lvl1 && !lvl2) state_d = S_IDLE;
      end
      default: begin
        state_d = S_POR;
        cnt_d   = '0;
      end
    endcase

    // Outputs decoded from next state so they are registered with it.
    run_d  = (state_d == S_PULSE) && (kind_d == KIND_RUN);
    halt_d = (state_d == S_PULSE) && (kind_d == KIND_HALT);
    rst_d  = (state_d == S_POR) ||
             ((state_d == S_PULSE) && (kind_d == KIND_RSTCLR));
    clr_d  = rst_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_POR;
      kind_q  <= KIND_RUN;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      halt_q  <= 1'b0;
      rst_q   <= 1'b1;
      clr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      halt_q  <= halt_d;
      rst_q   <= rst_d;
      clr_q   <= clr_d;
    end
  end

  assign cpu.sw_RUN   = run_q;
  assign cpu.sw_HALT  = halt_q;
  assign cpu.sw_RESET = rst_q;
  assign cpu.sw_CLEAR = clr_q;
  assign cpu.busy     = (state_q != S_IDLE);

endmodule
